// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces received bytes out to uart_tx, one per frame time
// Define DROP_CNT_EN to add the saturating ovf_cnt count of bytes dropped while full.
module uart_tx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int FRAME_CYC = 52080
) (
   input  logic          sclk,
   input  logic          s_rst_n,
   input  logic          wr_flag,
   input  logic [7:0]    wr_data,
   output logic          tx_trig,
   output logic [7:0]    tx_data,
   output logic [AW:0]   fifo_cnt,
   output logic          fifo_empty,
   output logic          fifo_full
`ifdef DROP_CNT_EN
   ,
   output logic [7:0]    ovf_cnt
`endif
);

   localparam int GW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [GW-1:0] GAP_ONE  = 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_CYC - 1);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_nxt;
   logic [AW:0]   cnt_nxt;
   logic          push;
   logic          pop;

   // Full is the registered flag, so a pop in the same cycle never makes room.
   assign push = wr_flag && !fifo_full;

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_cnt != '0) begin
               pop       = 1'b1;
               gap_nxt   = '0;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            gap_nxt = gap_cnt + GAP_ONE;
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt = fifo_cnt;
      case ({push, pop})
         2'b10:   cnt_nxt = fifo_cnt + CNT_ONE;
         2'b01:   cnt_nxt = fifo_cnt - CNT_ONE;
         default: cnt_nxt = fifo_cnt;
      endcase
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         gap_cnt <= gap_nxt;
      end
   end

   always_ff @(posedge sclk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         fifo_cnt   <= cnt_nxt;
         fifo_empty <= (cnt_nxt == '0);
         fifo_full  <= (cnt_nxt == FULL_CNT);
      end
   end

   // tx_data is only loaded on a pop, so it holds the last byte between triggers.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         tx_trig <= 1'b0;
         tx_data <= 8'h00;
      end else begin
         tx_trig <= pop;
         if (pop) begin
            tx_data <= mem[rd_ptr];
         end
      end
   end

`ifdef DROP_CNT_EN
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         ovf_cnt <= 8'h00;
      end else if (wr_flag && fifo_full && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with DEPTH=4, FRAME_CYC=20
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int FRAME = 20;

   logic          sclk = 1'b0;
   logic          s_rst_n;
   logic          wr_flag = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          tx_trig;
   logic [7:0]    tx_data;
   logic [AW:0]   fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;
`ifdef DROP_CNT_EN
   logic [7:0]    ovf_cnt;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int n_trig   = 0;

   logic [7:0] sb_q [$];
   int  m_cnt  = 0;
   bit  m_wait = 1'b0;
   int  m_gap  = 0;
   bit  m_trig = 1'b0;
   int  m_drop = 0;
   bit  m_push;
   bit  m_pop;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .FRAME_CYC(FRAME)) dut (
      .sclk       (sclk),
      .s_rst_n    (s_rst_n),
      .wr_flag    (wr_flag),
      .wr_data    (wr_data),
      .tx_trig    (tx_trig),
      .tx_data    (tx_data),
      .fifo_cnt   (fifo_cnt),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full)
`ifdef DROP_CNT_EN
      ,
      .ovf_cnt    (ovf_cnt)
`endif
   );

   always #5 sclk = ~sclk;

   // Reference model: accepted bytes go to the scoreboard, m_trig says when a trigger is due.
   always @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         m_cnt  = 0;
         m_wait = 1'b0;
         m_gap  = 0;
         m_trig = 1'b0;
         m_drop = 0;
         sb_q.delete();
      end else begin
         m_push = wr_flag && (m_cnt < DEPTH);
         m_pop  = !m_wait && (m_cnt != 0);
         if (wr_flag && !m_push && m_drop < 255) m_drop++;
         if (m_push) sb_q.push_back(wr_data);
         m_trig = m_pop;
         if (m_pop) begin
            m_wait = 1'b1;
            m_gap  = 0;
         end else if (m_wait) begin
            if (m_gap == FRAME - 1) m_wait = 1'b0;
            m_gap++;
         end
         m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      end
   end

   always @(negedge sclk) begin
      if (s_rst_n === 1'b1) begin
         chk_cnt++;
         if (fifo_cnt === (AW+1)'(m_cnt) && fifo_empty === (m_cnt == 0) &&
             fifo_full === (m_cnt == DEPTH))
            pass_cnt++;
         else
            $display("FAIL count_flags got cnt=%0d empty=%b full=%b need cnt=%0d empty=%b full=%b",
                     fifo_cnt, fifo_empty, fifo_full, m_cnt, (m_cnt == 0), (m_cnt == DEPTH));
         if (tx_trig !== 1'b0 || m_trig) begin
            chk_cnt++;
            if (tx_trig === m_trig) pass_cnt++;
            else $display("FAIL trig_timing got %b need %b at %0t", tx_trig, m_trig, $time);
         end
         if (tx_trig === 1'b1) begin
            n_trig++;
            chk_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_extra got byte %02h need no trigger", tx_data);
            end else begin
               logic [7:0] exp_b;
               exp_b = sb_q.pop_front();
               if (tx_data === exp_b) pass_cnt++;
               else $display("FAIL sb_data got %02h need %02h", tx_data, exp_b);
            end
         end
      end
   end

   task automatic wr_byte(input logic [7:0] b);
      wr_flag = 1'b1;
      wr_data = b;
      @(negedge sclk);
      wr_flag = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      chk_cnt++;
      if ({tx_trig, tx_data, fifo_cnt, fifo_empty, fifo_full} === {1'b0, 8'h00, 3'd0, 1'b1, 1'b0})
         pass_cnt++;
      else
         $display("FAIL reset_values got trig=%b data=%02h cnt=%0d empty=%b full=%b need 0/00/0/1/0",
                  tx_trig, tx_data, fifo_cnt, fifo_empty, fifo_full);
`ifdef DROP_CNT_EN
      chk_cnt++;
      if (ovf_cnt === 8'h00) pass_cnt++;
      else $display("FAIL reset_ovf got %02h need 00", ovf_cnt);
`endif
      repeat (2) @(negedge sclk);
      s_rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit bad = 1'b0;
      repeat (3) @(negedge sclk);
      wr_byte(8'hA5);
      chk_cnt++;
      if (tx_trig === 1'b0 && fifo_cnt === 3'd1) pass_cnt++;
      else $display("FAIL single_k1 got trig=%b cnt=%0d need trig=0 cnt=1", tx_trig, fifo_cnt);
      @(negedge sclk);
      chk_cnt++;
      if (tx_trig === 1'b1 && tx_data === 8'hA5) pass_cnt++;
      else $display("FAIL single_k2 got trig=%b data=%02h need trig=1 data=a5", tx_trig, tx_data);
      for (int i = 0; i < FRAME + 3; i++) begin
         @(negedge sclk);
         if (tx_trig !== 1'b0 || tx_data !== 8'hA5) bad = 1'b1;
      end
      chk_cnt++;
      if (!bad && fifo_empty === 1'b1 && fifo_cnt === 3'd0) pass_cnt++;
      else $display("FAIL single_hold got bad=%b empty=%b cnt=%0d need bad=0 empty=1 cnt=0",
                    bad, fifo_empty, fifo_cnt);
   endtask

   task automatic test_burst();
      logic [7:0] bb [3] = '{8'h11, 8'h22, 8'h33};
      int tt [3] = '{0, 0, 0};
      int nt   = 0;
      int peak = 0;
      repeat (5) @(negedge sclk);
      for (int i = 0; i < 80; i++) begin
         if (i < 3) begin
            wr_flag = 1'b1;
            wr_data = bb[i];
         end else begin
            wr_flag = 1'b0;
         end
         @(negedge sclk);
         if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
         if (tx_trig === 1'b1) begin
            if (nt < 3) tt[nt] = i;
            nt++;
         end
      end
      wr_flag = 1'b0;
      chk_cnt++;
      if (nt == 3 && tt[0] == 1) pass_cnt++;
      else $display("FAIL burst_trigs got n=%0d first=%0d need n=3 first=1", nt, tt[0]);
      chk_cnt++;
      if (tt[1] - tt[0] == FRAME + 1 && tt[2] - tt[1] == FRAME + 1) pass_cnt++;
      else $display("FAIL burst_spacing got %0d,%0d need 21,21", tt[1] - tt[0], tt[2] - tt[1]);
      chk_cnt++;
      if (peak == 2) pass_cnt++;
      else $display("FAIL burst_peak got %0d need 2", peak);
   endtask

   task automatic test_overflow();
      int n0;
      repeat (5) @(negedge sclk);
      n0 = n_trig;
      wr_byte(8'hEE);
      @(negedge sclk);
      for (int i = 0; i < 6; i++) begin
         wr_flag = 1'b1;
         wr_data = 8'(i + 1);
         @(negedge sclk);
      end
      wr_flag = 1'b0;
      chk_cnt++;
      if (fifo_cnt === 3'd4 && fifo_full === 1'b1) pass_cnt++;
      else $display("FAIL ovf_full got cnt=%0d full=%b need cnt=4 full=1", fifo_cnt, fifo_full);
`ifdef DROP_CNT_EN
      chk_cnt++;
      if (ovf_cnt === 8'(m_drop)) pass_cnt++;
      else $display("FAIL ovf_cnt got %0d need %0d", ovf_cnt, m_drop);
`endif
      repeat (5 * (FRAME + 1) + 5) @(negedge sclk);
      chk_cnt++;
      if (n_trig - n0 == 5 && fifo_empty === 1'b1) pass_cnt++;
      else $display("FAIL ovf_drain got trigs=%0d empty=%b need trigs=5 empty=1", n_trig - n0, fifo_empty);
   endtask

   task automatic test_wrap();
      int n0;
      n0 = n_trig;
      for (int b = 0; b < 10; b++) begin
         wr_byte(8'(b));
         if (b % 3 == 2) repeat (70) @(negedge sclk);
      end
      repeat (70) @(negedge sclk);
      chk_cnt++;
      if (n_trig - n0 == 10 && fifo_empty === 1'b1 && sb_q.size() == 0) pass_cnt++;
      else $display("FAIL wrap_drain got trigs=%0d empty=%b left=%0d need trigs=10 empty=1 left=0",
                    n_trig - n0, fifo_empty, sb_q.size());
   endtask

   task automatic test_reset_mid_wait();
      int nt = 0;
      wr_byte(8'hAA);
      @(negedge sclk);
      wr_byte(8'hC1);
      wr_byte(8'hC2);
      wr_byte(8'hC3);
      repeat (3) @(negedge sclk);
      chk_cnt++;
      if (fifo_cnt === 3'd3) pass_cnt++;
      else $display("FAIL rst_pre got cnt=%0d need 3", fifo_cnt);
      #2 s_rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({tx_trig, tx_data, fifo_cnt, fifo_empty, fifo_full} === {1'b0, 8'h00, 3'd0, 1'b1, 1'b0})
         pass_cnt++;
      else
         $display("FAIL rst_async got trig=%b data=%02h cnt=%0d empty=%b full=%b need 0/00/0/1/0",
                  tx_trig, tx_data, fifo_cnt, fifo_empty, fifo_full);
      @(negedge sclk);
      s_rst_n = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge sclk);
         if (tx_trig === 1'b1) nt++;
      end
      chk_cnt++;
      if (nt == 0) pass_cnt++;
      else $display("FAIL rst_no_trig got %0d trigs need 0", nt);
      wr_byte(8'h5A);
      chk_cnt++;
      if (tx_trig === 1'b0) pass_cnt++;
      else $display("FAIL rst_new_k1 got trig=%b need 0", tx_trig);
      @(negedge sclk);
      chk_cnt++;
      if (tx_trig === 1'b1 && tx_data === 8'h5A) pass_cnt++;
      else $display("FAIL rst_new_k2 got trig=%b data=%02h need trig=1 data=5a", tx_trig, tx_data);
      repeat (FRAME + 5) @(negedge sclk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      s_rst_n = 1'b1;
      #2 s_rst_n = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
